// File: rtl/muldiv_unit_pkg.sv
// Shared encodings and default sizes for the iterative multiply/divide unit.
// The width defaults match the 32x32 register file that this unit writes back into.
package muldiv_unit_pkg;

   localparam int WIDTH_DEF      = 32;
   localparam int REG_ADDR_W_DEF = 5;
   localparam int CNT_W_DEF      = 6;

   typedef enum logic [1:0] {
      OP_MULLO = 2'd0,
      OP_MULHI = 2'd1,
      OP_DIVU  = 2'd2,
      OP_REMU  = 2'd3
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      WB   = 2'd2
   } state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue and register-file write-back bundle of the multiply/divide unit.
interface muldiv_unit_if
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH      = WIDTH_DEF,
   parameter int REG_ADDR_W = REG_ADDR_W_DEF
);
   logic                  start;
   logic [1:0]            op;
   logic [WIDTH-1:0]      op_a;
   logic [WIDTH-1:0]      op_b;
   logic [REG_ADDR_W-1:0] dst_reg;
   logic                  busy;
   logic                  wr_enable;
   logic [REG_ADDR_W-1:0] wr_reg;
   logic [WIDTH-1:0]      wr_data;

   modport master (
      output start, op, op_a, op_b, dst_reg,
      input  busy, wr_enable, wr_reg, wr_data
   );

   modport slave (
      input  start, op, op_a, op_b, dst_reg,
      output busy, wr_enable, wr_reg, wr_data
   );
endinterface

// File: rtl/muldiv_datapath.sv
// Shift-add multiplier and restoring divider stepping one bit per strobe.
// Both run in lockstep from the same operands; the latched op only selects the result.
module muldiv_datapath
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             init,
   input  logic             step,
   input  op_t              op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result
);

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   divisor;

   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     shifted;
   logic [WIDTH-1:0]   diff;
   logic               borrow;

   always_comb begin
      add_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, divisor} : '0);
      shifted = {rem, quo[WIDTH-1]};
      borrow  = shifted < {1'b0, divisor};
      // Only consumed when no borrow, where the true difference is below the divisor.
      diff    = shifted[WIDTH-1:0] - divisor;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod    <= '0;
         rem     <= '0;
         quo     <= '0;
         divisor <= '0;
      end else if (init) begin
         prod    <= {{WIDTH{1'b0}}, a};
         rem     <= '0;
         quo     <= a;
         divisor <= b;
      end else if (step) begin
         prod <= {add_sum, prod[WIDTH-1:1]};
         rem  <= borrow ? shifted[WIDTH-1:0] : diff;
         quo  <= {quo[WIDTH-2:0], ~borrow};
      end
   end

   always_comb begin
      result = '0;
      case (op)
         OP_MULLO: result = prod[WIDTH-1:0];
         OP_MULHI: result = prod[2*WIDTH-1:WIDTH];
         OP_DIVU:  result = quo;
         OP_REMU:  result = rem;
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit writing its result to the register file.
// state | meaning
// IDLE  | waiting for start; operands latched on the issue edge
// CALC  | one datapath iteration per cycle, WIDTH cycles
// WB    | one-cycle register-file write; a start here issues the next op
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH      = WIDTH_DEF,
   parameter int REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic          clk,
   input  logic          rst,
   muldiv_unit_if.slave  bus
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      count;
   op_t                   op_q;
   logic [REG_ADDR_W-1:0] dst_q;
   logic [REG_ADDR_W-1:0] wr_reg_q;
   logic [WIDTH-1:0]      wr_data_q;
   logic [WIDTH-1:0]      result;
   logic                  init;
   logic                  step;
   logic                  in_wb;

   always_comb begin
      state_nxt = state;
      init      = 1'b0;
      step      = 1'b0;
      in_wb     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               init      = 1'b1;
               state_nxt = CALC;
            end
         end
         CALC: begin
            step = 1'b1;
            if (count == LAST) state_nxt = WB;
         end
         WB: begin
            in_wb = 1'b1;
            if (bus.start) begin
               init      = 1'b1;
               state_nxt = CALC;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         op_q      <= OP_MULLO;
         dst_q     <= '0;
         wr_reg_q  <= '0;
         wr_data_q <= '0;
      end else begin
         state <= state_nxt;
         if (init) begin
            count <= '0;
            op_q  <= op_t'(bus.op);
            dst_q <= bus.dst_reg;
         end else if (step) begin
            count <= count + 1'b1;
         end
         if (in_wb) begin
            wr_reg_q  <= dst_q;
            wr_data_q <= result;
         end
      end
   end

   muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
      .clk    (clk),
      .rst    (rst),
      .init   (init),
      .step   (step),
      .op     (op_q),
      .a      (bus.op_a),
      .b      (bus.op_b),
      .result (result)
   );

   // Outside WB the write port replays the last written value and index.
   assign bus.busy      = (state != IDLE);
   assign bus.wr_enable = in_wb;
   assign bus.wr_reg    = in_wb ? dst_q  : wr_reg_q;
   assign bus.wr_data   = in_wb ? result : wr_data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed operations, busy/back-to-back, abort and reg-file readback.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   localparam int W   = 32;
   localparam int LAT = 32;

   typedef struct {
      logic [4:0]  rg;
      logic [31:0] data;
      int          issue;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   muldiv_unit_if #(.WIDTH(W), .REG_ADDR_W(5)) bus ();

   muldiv_unit #(.WIDTH(W), .REG_ADDR_W(5), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   exp_t        sbq[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   logic [31:0] rf[32];
   logic        prev_we = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      if (bus.wr_enable) rf[bus.wr_reg] = bus.wr_data;
   end

   always @(negedge clk) begin
      exp_t e;
      if (bus.wr_enable) begin
         check("single_cycle_strobe", 32'(prev_we), 32'd0);
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: reg %0d data %h while none expected",
                     bus.wr_reg, bus.wr_data);
         end else begin
            e = sbq.pop_front();
            check("wr_reg", 32'(bus.wr_reg), 32'(e.rg));
            check("wr_data", bus.wr_data, e.data);
            check("latency", 32'(cyc - e.issue), 32'(LAT));
         end
      end
      prev_we = bus.wr_enable;
   end

   // Drives one issue cycle from the current negedge; returns at the next negedge.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] dst, input logic [31:0] exp, input bit accept);
      bus.start   = 1'b1;
      bus.op      = op;
      bus.op_a    = a;
      bus.op_b    = b;
      bus.dst_reg = dst;
      if (accept) sbq.push_back('{rg: dst, data: exp, issue: cyc + 1});
      @(negedge clk);
      bus.start   = 1'b0;
      bus.op      = 2'($urandom);
      bus.op_a    = $urandom;
      bus.op_b    = $urandom;
      bus.dst_reg = 5'($urandom);
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (bus.busy && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (bus.busy) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: busy still %0d after %0d cycles, wanted 0", bus.busy, n);
      end
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] dst, input logic [31:0] exp);
      int n;
      @(negedge clk);
      issue(op, a, b, dst, exp, 1'b1);
      wait_idle(n);
      check("busy_cycles", 32'(n), 32'(LAT + 1));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      bus.start   = 1'b0;
      bus.op      = 2'd0;
      bus.op_a    = '0;
      bus.op_b    = '0;
      bus.dst_reg = '0;
      #2 rst = 1'b1;
      #1;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_wr_enable", 32'(bus.wr_enable), 32'd0);
      check("rst_wr_data", bus.wr_data, 32'd0);
      check("rst_wr_reg", 32'(bus.wr_reg), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      run_op(OP_MULLO, 32'hFFFF_FFFF, 32'h2, 5'd5, 32'hFFFF_FFFE);
      check("hold_wr_data", bus.wr_data, 32'hFFFF_FFFE);
      check("hold_wr_reg", 32'(bus.wr_reg), 32'd5);
      run_op(OP_MULHI, 32'hFFFF_FFFF, 32'h2, 5'd5, 32'h0000_0001);
      run_op(OP_DIVU, 32'd100, 32'd7, 5'd9, 32'd14);
      run_op(OP_REMU, 32'd100, 32'd7, 5'd9, 32'd2);
      run_op(OP_DIVU, 32'h1234_5678, 32'h0, 5'd6, 32'hFFFF_FFFF);
      run_op(OP_REMU, 32'h1234_5678, 32'h0, 5'd7, 32'h1234_5678);
      run_op(OP_MULHI, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFE);
      run_op(OP_MULLO, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'h0000_0001);
      run_op(OP_MULLO, 32'h0, 32'hDEAD_BEEF, 5'd0, 32'h0);
      run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h1, 5'd10, 32'hFFFF_FFFF);
      run_op(OP_REMU, 32'hFFFF_FFFF, 32'h10, 5'd11, 32'hF);

      // start during CALC must be dropped
      @(negedge clk);
      issue(OP_DIVU, 32'd1000, 32'd3, 5'd12, 32'd333, 1'b1);
      repeat (9) @(negedge clk);
      issue(OP_MULLO, 32'd5, 32'd5, 5'd13, 32'd25, 1'b0);
      wait_idle(n);
      repeat (40) @(negedge clk);
      check("ignored_start_queue", 32'(sbq.size()), 32'd0);

      // back-to-back: start held at the WB exit edge
      @(negedge clk);
      issue(OP_REMU, 32'd1000, 32'd3, 5'd14, 32'd1, 1'b1);
      n = 0;
      while (!bus.wr_enable && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus.wr_enable) begin
         checks++;
         errors++;
         $display("FAIL wb_timeout: wr_enable %0d after %0d cycles, wanted 1", bus.wr_enable, n);
      end else begin
         issue(OP_MULHI, 32'h0001_0000, 32'h0003_0000, 5'd15, 32'h3, 1'b1);
         wait_idle(n);
         check("b2b_busy_cycles", 32'(n), 32'(LAT + 1));
      end

      // abort mid-CALC
      @(negedge clk);
      issue(OP_MULLO, 32'd7, 32'd9, 5'd16, 32'd63, 1'b0);
      repeat (19) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_wr_enable", 32'(bus.wr_enable), 32'd0);
      check("abort_wr_data", bus.wr_data, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      check("abort_busy_after", 32'(bus.busy), 32'd0);

      // register-file integration
      run_op(OP_MULLO, 32'h0001_2345, 32'h100, 5'd1, 32'h0123_4500);
      run_op(OP_DIVU, 32'd1000, 32'd10, 5'd2, 32'd100);
      run_op(OP_REMU, 32'd1000, 32'd33, 5'd3, 32'd10);
      run_op(OP_MULHI, 32'h8000_0000, 32'h4, 5'd4, 32'h2);
      check("rf_r1", rf[1], 32'h0123_4500);
      check("rf_r2", rf[2], 32'd100);
      check("rf_r3", rf[3], 32'd10);
      check("rf_r4", rf[4], 32'h2);
      check("final_queue", 32'(sbq.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative unsigned multiply/divide execution unit that sits directly downstream of the 32x32 register file.
- Consumes the two register-file read operands and computes one of four operations over WIDTH cycles.
- Drives the register file write port (wrEnable/wrReg/wrData) with the result for exactly one cycle.
- A single operation is in flight at a time; busy backpressures issue.

Parameters:
- WIDTH, 32, operand/result width; also the iteration count.
- REG_ADDR_W, 5, destination register index width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  issue request, sampled on a clk edge while idle.
- op  input  2  operation: 0 MULLO (low WIDTH of a*b), 1 MULHI (high WIDTH of a*b), 2 DIVU (a/b), 3 REMU (a%b).
- opA  input  WIDTH  operand a (register file rdData1).
- opB  input  WIDTH  operand b (register file rdData2).
- dstReg  input  REG_ADDR_W  destination register index.
- busy  output  1  high whenever state is not IDLE.
- wrEnable  output  1  one-cycle write strobe to the register file.
- wrReg  output  REG_ADDR_W  write index; valid while wrEnable is high.
- wrData  output  WIDTH  result; valid while wrEnable is high.

Behaviour:
- Reset (async, any time): state=IDLE, busy=0, wrEnable=0, wrReg=0, wrData=0, counter and datapath registers=0.
  - Reset mid-operation aborts the operation; no write is issued.
- FSM states are IDLE, CALC and WB.
- IDLE: on an edge with start=1, latch op, opA, opB and dstReg, set count=0, initialise the datapath, and go to CALC.
  - Inputs are don't-care after the issue edge.
- CALC: one iteration per edge; count increments.
  - The edge at which count==WIDTH-1 completes the final iteration and moves to WB.
  - CALC therefore lasts exactly WIDTH cycles.
- WB: wrEnable=1 and wrReg=latched dstReg, with wrData equal to the selected result, for exactly one cycle.
  - The next edge returns to IDLE with wrEnable=0.
  - The register file captures the result on that same edge.
- Latency: if the issue is edge E, WB is the cycle after edge E+WIDTH, and the register file is written at edge E+WIDTH+1 (E+33 for WIDTH=32).
  - Back-to-back issue is possible: start may be accepted at edge E+WIDTH+1, the edge that leaves WB.
- start while busy=1 is ignored and not queued.
- wrData and wrReg hold their last WB values while wrEnable=0.
- Multiply:
  - 2*WIDTH product register, shift-add, one multiplier bit per iteration, unsigned.
  - MULLO returns product[WIDTH-1:0]; MULHI returns product[2*WIDTH-1:WIDTH].
  - Overflow is impossible by construction.
- Divide:
  - Restoring division, one quotient bit per iteration.
  - Uses a WIDTH+1-bit partial remainder so the trial subtract borrow is explicit, unsigned.
- Divide by zero (opB==0): DIVU returns all ones (0xFFFFFFFF); REMU returns opA.
  - It still takes the full WIDTH cycles; latency is identical.
- Zero-operand multiply takes full latency; there is no early termination.
- dstReg=0 is written like any other index.
- Simultaneous rst and start: rst wins; state stays IDLE.

Decomposition:
- Shared package contents:
  - op encodings OP_MULLO/OP_MULHI/OP_DIVU/OP_REMU (2-bit);
  - state encodings IDLE/CALC/WB;
  - WIDTH and REG_ADDR_W defaults shared with the register file.
- One sub-module, muldiv_datapath, holds the product/remainder/quotient shift registers and the add/subtract step.
  - It is controlled by init/step strobes and the latched op.
  - The top level holds the FSM, counter and write-port registers.

Test Plan:
- Reset: assert rst mid-simulation with clk free-running -> busy=0, wrEnable=0, wrData=0 immediately, without waiting for an edge.
- MULLO/MULHI: opA=0xFFFFFFFF, opB=0x00000002, dstReg=5 -> wrEnable pulses one cycle 33 edges after issue.
  - MULLO gives wrData=0xFFFFFFFE, wrReg=5; MULHI gives wrData=0x00000001.
  - busy=1 for exactly 33 cycles.
- DIVU/REMU: opA=100, opB=7, dstReg=9 -> DIVU wrData=14; REMU wrData=2; wrReg=9.
- Divide by zero: opA=0x12345678, opB=0 -> DIVU wrData=0xFFFFFFFF; REMU wrData=0x12345678; same 33-cycle latency.
- Busy and back-to-back: pulse start with different operands at cycle 10 of an operation -> ignored; only the first result is written.
  - A start held high at the WB exit edge is accepted, and the second result follows 33 edges later.
- Abort and integration: assert rst at CALC cycle 20 -> no wrEnable pulse.
  - With the register file connected, write results to regs 1..4, then read back via rdReg1/rdReg2 -> values match.
